// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, registered address stage and a
// FETCH_LAT-deep delay line aligning sync/blank with returned pixel data.
// Optional colour-bar source: define VGA_TIMING_GEN_TESTPATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FETCH_LAT = 1,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_en,
  input  logic [23:0]       vga_data,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              addr_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start,
  output logic              line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (FETCH_LAT < 0 || FETCH_LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: FETCH_LAT must be 0..4");
  end
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_field
    $error("vga_timing_gen: timing fields must be non-zero");
  end
  if (H_TOTAL > (2 ** ADDR_W) || V_TOTAL > (2 ** ADDR_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed ADDR_W range");
  end

  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_ACT  = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_ACT  = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_SS   = ADDR_W'(H_ACTIVE + H_FP);
  localparam logic [ADDR_W-1:0] H_SE   = ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ADDR_W-1:0] V_SS   = ADDR_W'(V_ACTIVE + V_FP);
  localparam logic [ADDR_W-1:0] V_SE   = ADDR_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [ADDR_W-1:0] h_cnt, v_cnt;
  logic              av_c, hs_c, vs_c;

  assign av_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_c = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_c = (v_cnt >= V_SS) && (v_cnt < V_SE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Bit 0 of each pipe is the address stage; bit FETCH_LAT is what drives the pins.
  // *_nxt is the value each pipe takes on the next tick, so *_nxt[FETCH_LAT]
  // is the blanking state that the RGB register must be loaded under.
  logic [FETCH_LAT:0] vld_pipe, hs_pipe, vs_pipe;
  logic [FETCH_LAT:0] vld_nxt, hs_nxt, vs_nxt;

  if (FETCH_LAT == 0) begin : g_nodly
    assign vld_nxt = av_c;
    assign hs_nxt  = hs_c;
    assign vs_nxt  = vs_c;
  end else begin : g_dly
    assign vld_nxt = {vld_pipe[FETCH_LAT-1:0], av_c};
    assign hs_nxt  = {hs_pipe[FETCH_LAT-1:0], hs_c};
    assign vs_nxt  = {vs_pipe[FETCH_LAT-1:0], vs_c};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_addr      <= '0;
      v_addr      <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      vld_pipe    <= '0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
    end else if (pix_en) begin
      h_addr      <= av_c ? h_cnt : '0;
      v_addr      <= av_c ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0);
      vld_pipe    <= vld_nxt;
      hs_pipe     <= hs_nxt;
      vs_pipe     <= vs_nxt;
    end
  end

  assign addr_valid = vld_pipe[0];
  assign valid      = vld_pipe[FETCH_LAT];
  assign hsync      = SYNC_POL ? hs_pipe[FETCH_LAT] : ~hs_pipe[FETCH_LAT];
  assign vsync      = SYNC_POL ? vs_pipe[FETCH_LAT] : ~vs_pipe[FETCH_LAT];

  logic [23:0] pix;

`ifdef VGA_TIMING_GEN_TESTPATTERN_EN
  if (ADDR_W < 3) begin : g_bad_aw
    $error("vga_timing_gen: test pattern needs ADDR_W >= 3");
  end

  // Bar index travels with the blanking pipe so bars line up with valid.
  logic [FETCH_LAT:0][2:0] bar_pipe, bar_nxt;
  logic [2:0]              bar_c, bar;
  logic                    unused_data;

  assign unused_data = ^vga_data;
  assign bar_c = av_c ? h_cnt[ADDR_W-1 -: 3] : 3'd0;

  if (FETCH_LAT == 0) begin : g_bar_nodly
    assign bar_nxt = bar_c;
  end else begin : g_bar_dly
    assign bar_nxt = {bar_pipe[FETCH_LAT-1:0], bar_c};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     bar_pipe <= '0;
    else if (pix_en) bar_pipe <= bar_nxt;
  end

  // white, yellow, cyan, green, magenta, red, blue, black
  assign bar = bar_nxt[FETCH_LAT];
  assign pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`else
  assign pix = vga_data;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {vga_r, vga_g, vga_b} <= '0;
    end else if (pix_en) begin
      {vga_r, vga_g, vga_b} <= vld_nxt[FETCH_LAT] ? pix : 24'h0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two instances (FETCH_LAT=2/low sync,
// FETCH_LAT=0/high sync) on a small raster, checked against a reference model.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int L0 = 2, L1 = 0;

  logic clk = 1'b0, resetn = 1'b0, pix_en = 1'b0;
  logic [23:0] vga_data = 24'h0;

  logic [9:0] h_addr0, v_addr0, h_addr1, v_addr1;
  logic addr_valid0, hsync0, vsync0, valid0, fs0, ls0;
  logic addr_valid1, hsync1, vsync1, valid1, fs1, ls1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .FETCH_LAT(L0), .ADDR_W(10)
  ) u0 (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(vga_data),
    .h_addr(h_addr0), .v_addr(v_addr0), .addr_valid(addr_valid0),
    .hsync(hsync0), .vsync(vsync0), .valid(valid0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .frame_start(fs0), .line_start(ls0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .FETCH_LAT(L1), .ADDR_W(10)
  ) u1 (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(vga_data),
    .h_addr(h_addr1), .v_addr(v_addr1), .addr_valid(addr_valid1),
    .hsync(hsync1), .vsync(vsync1), .valid(valid1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .frame_start(fs1), .line_start(ls1)
  );

  typedef struct packed {logic [9:0] ha; logic [9:0] va; logic av; logic fs; logic ls;} s0_t;
  typedef struct packed {logic hs; logic vs; logic vld; logic [23:0] rgb;} s1_t;
  typedef struct packed {logic hs; logic vs; logic av;} raw_t;

  raw_t q0[$], q1[$];
  s0_t  e_s0;
  s1_t  e_o0, e_o1;
  int   mh, mv, nt, nf, nprint;
  bit   chk;

  function automatic s1_t deliver(raw_t p, bit pol, logic [23:0] d);
    s1_t o;
    o.hs  = p.hs ? pol : ~pol;
    o.vs  = p.vs ? pol : ~pol;
    o.vld = p.av;
    o.rgb = p.av ? d : 24'h0;
    return o;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; e_s0 = '0;
    e_o0 = deliver('0, 1'b0, 24'h0);
    e_o1 = deliver('0, 1'b1, 24'h0);
    q0.delete(); q1.delete();
    repeat (L0) q0.push_back('0);
    repeat (L1) q1.push_back('0);
  endtask

  // One clock: the model advances only on a live tick, pushing the raw
  // stage into each instance's delay queue and popping what reaches the pins.
  task automatic tick(input bit en);
    raw_t r;
    pix_en = en;
    @(posedge clk);
    if (en && resetn) begin
      r.av = (mh < HA) && (mv < VA);
      r.hs = (mh >= HA + HF) && (mh < HA + HF + HS);
      r.vs = (mv >= VA + VF) && (mv < VA + VF + VS);
      e_s0.ha = r.av ? 10'(mh) : 10'd0;
      e_s0.va = r.av ? 10'(mv) : 10'd0;
      e_s0.av = r.av;
      e_s0.fs = (mh == 0) && (mv == 0);
      e_s0.ls = (mh == 0);
      q0.push_back(r); e_o0 = deliver(q0.pop_front(), 1'b0, vga_data);
      q1.push_back(r); e_o1 = deliver(q1.pop_front(), 1'b1, vga_data);
      mh++;
      if (mh == HT) begin mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1; end
    end
    #1 vga_data = 24'($urandom);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (chk) begin
        nt += 4;
        if ({h_addr0, v_addr0, addr_valid0, fs0, ls0} !== e_s0) begin
          nf++; if (nprint++ < 40) $display("FAIL stage0_u0 got %h want %h", {h_addr0, v_addr0, addr_valid0, fs0, ls0}, e_s0);
        end
        if ({h_addr1, v_addr1, addr_valid1, fs1, ls1} !== e_s0) begin
          nf++; if (nprint++ < 40) $display("FAIL stage0_u1 got %h want %h", {h_addr1, v_addr1, addr_valid1, fs1, ls1}, e_s0);
        end
        if ({hsync0, vsync0, valid0, r0, g0, b0} !== e_o0) begin
          nf++; if (nprint++ < 40) $display("FAIL pins_u0 got %h want %h", {hsync0, vsync0, valid0, r0, g0, b0}, e_o0);
        end
        if ({hsync1, vsync1, valid1, r1, g1, b1} !== e_o1) begin
          nf++; if (nprint++ < 40) $display("FAIL pins_u1 got %h want %h", {hsync1, vsync1, valid1, r1, g1, b1}, e_o1);
        end
      end
    end
  endtask

  task automatic test_reset();
    pix_en = 1'b1; resetn = 1'b0; model_reset(); chk = 1'b1;
    repeat (3) tick(1'b1);
    nt++;
    if ({hsync0, vsync0, hsync1, vsync1} !== 4'b1100) begin
      nf++; $display("FAIL reset_sync got %b want 1100", {hsync0, vsync0, hsync1, vsync1});
    end
    nt++;
    if ({valid0, valid1, addr_valid0, fs0, ls0, r0, g0, b0, h_addr0, v_addr0} !== 49'd0) begin
      nf++; $display("FAIL reset_outputs got %h want 0", {valid0, valid1, addr_valid0, fs0, ls0, r0, g0, b0, h_addr0, v_addr0});
    end
  endtask

  task automatic test_first_tick();
    resetn = 1'b1;
    tick(1'b1);
    nt++;
    if ({fs0, ls0, addr_valid0, h_addr0, v_addr0} !== {3'b111, 20'd0}) begin
      nf++; $display("FAIL first_tick got %h want %h", {fs0, ls0, addr_valid0, h_addr0, v_addr0}, {3'b111, 20'd0});
    end
    nt++;
    if ({valid0, valid1} !== 2'b01) begin
      nf++; $display("FAIL first_valid got %b want 01", {valid0, valid1});
    end
    tick(1'b1);
    nt++;
    if ({fs0, ls0, fs1, ls1} !== 4'b0000) begin
      nf++; $display("FAIL pulse_width got %b want 0000", {fs0, ls0, fs1, ls1});
    end
  endtask

  task automatic test_frame();
    int t_fs = -1, per = -1, n_fs = 0, n_hs = 0, n_vs = 0, n_ls = 0;
    int off_h0 = -1, off_h1 = -1, off_v0 = -1;
    for (int i = 0; i < 2 * FR + 8; i++) begin
      tick(1'b1);
      if (fs0 === 1'b1) begin
        if (t_fs >= 0 && per < 0) per = i - t_fs;
        t_fs = i; n_fs++;
      end
      if (n_fs == 1) begin
        if (hsync0 === 1'b0) begin n_hs++; if (off_h0 < 0) off_h0 = i - t_fs; end
        if (hsync1 === 1'b1 && off_h1 < 0) off_h1 = i - t_fs;
        if (vsync0 === 1'b0) begin n_vs++; if (off_v0 < 0) off_v0 = i - t_fs; end
        if (ls0 === 1'b1) n_ls++;
      end
    end
    nt++; if (per != FR) begin nf++; $display("FAIL frame_period got %0d want %0d", per, FR); end
    nt++; if (n_hs != HS * VT) begin nf++; $display("FAIL hsync_ticks got %0d want %0d", n_hs, HS * VT); end
    nt++; if (n_vs != VS * HT) begin nf++; $display("FAIL vsync_ticks got %0d want %0d", n_vs, VS * HT); end
    nt++; if (n_ls != VT) begin nf++; $display("FAIL lines_per_frame got %0d want %0d", n_ls, VT); end
    nt++; if (off_h0 != HA + HF + L0) begin nf++; $display("FAIL hsync_start_u0 got %0d want %0d", off_h0, HA + HF + L0); end
    nt++; if (off_h1 != HA + HF + L1) begin nf++; $display("FAIL hsync_start_u1 got %0d want %0d", off_h1, HA + HF + L1); end
    nt++; if (off_v0 != (VA + VF) * HT + L0) begin nf++; $display("FAIL vsync_start got %0d want %0d", off_v0, (VA + VF) * HT + L0); end
  endtask

  task automatic test_pix_en();
    int last = -1, per = -1;
    for (int c = 0; c < 4 * HT + 4; c++) begin
      tick(c % 2 == 0);
      if (c % 2 == 0 && ls0 === 1'b1) begin
        if (last >= 0 && per < 0) per = c - last;
        last = c;
      end
    end
    nt++; if (per != 2 * HT) begin nf++; $display("FAIL half_rate_line got %0d want %0d", per, 2 * HT); end
    tick(1'b0);
    nt++;
    if ({h_addr0, v_addr0} !== {e_s0.ha, e_s0.va}) begin
      nf++; $display("FAIL hold_addr got %h want %h", {h_addr0, v_addr0}, {e_s0.ha, e_s0.va});
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(mv == VA + VF && mh == HA + HF + 1) && n < 2 * FR) begin tick(1'b1); n++; end
    nt++; if (n >= 2 * FR) begin nf++; $display("FAIL mid_reset_seek got %0d ticks want < %0d", n, 2 * FR); end
    repeat (3) tick(1'b1);
    nt++; if ({hsync0, vsync0} !== 2'b00) begin nf++; $display("FAIL mid_sync_active got %b want 00", {hsync0, vsync0}); end
    resetn = 1'b0; model_reset();
    #1;
    nt++;
    if ({hsync0, vsync0, hsync1, vsync1} !== 4'b1100) begin
      nf++; $display("FAIL mid_reset_sync got %b want 1100", {hsync0, vsync0, hsync1, vsync1});
    end
    tick(1'b1); tick(1'b1);
    resetn = 1'b1;
    tick(1'b1);
    nt++;
    if ({fs0, ls0, addr_valid0, h_addr0, v_addr0} !== {3'b111, 20'd0}) begin
      nf++; $display("FAIL restart_tick got %h want %h", {fs0, ls0, addr_valid0, h_addr0, v_addr0}, {3'b111, 20'd0});
    end
    nt++; if ({hsync0, vsync0} !== 2'b11) begin nf++; $display("FAIL restart_sync got %b want 11", {hsync0, vsync0}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 700; i++) tick(bit'($urandom_range(0, 1)));
    nt++;
    if ({h_addr1, v_addr1, addr_valid1} !== {e_s0.ha, e_s0.va, e_s0.av}) begin
      nf++; $display("FAIL random_en_addr got %h want %h", {h_addr1, v_addr1, addr_valid1}, {e_s0.ha, e_s0.va, e_s0.av});
    end
  endtask

  initial begin
    nt = 0; nf = 0; nprint = 0; chk = 1'b0;
    model_reset();
    fork monitor(); join_none
    test_reset();
    test_first_tick();
    test_frame();
    test_pix_en();
    test_mid_reset();
    test_back_to_back();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
